// File: rtl/slow_mem_responder_pkg.sv
// Shared definitions for the 128-bit line-level memory handshake:
// line/address geometry and the responder FSM state encoding.
package mem_if_pkg;

    localparam int LINE_W  = 128;
    localparam int ADDR_HI = 31;
    localparam int ADDR_LO = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2,
        TURN = 2'd3
    } state_t;

endpackage

// File: rtl/slow_mem_responder_if.sv
// Line-level memory request/response bundle shared by caches (master)
// and memory-side responders (slave).
interface slow_mem_responder_if;
    import mem_if_pkg::*;

    logic                    mem_read;
    logic                    mem_write;
    logic [ADDR_HI:ADDR_LO]  mem_addr;
    logic [LINE_W-1:0]       mem_wdata;
    logic [LINE_W-1:0]       mem_rdata;
    logic                    mem_ready;

    modport master (
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );

endinterface

// File: rtl/slow_mem_responder_line_array.sv
// Single-port line storage with synchronous write and registered read;
// the read register holds its value across writes and idle cycles.
module mem_line_array
    import mem_if_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [LINE_W-1:0]     wdata,
    output logic [LINE_W-1:0]     rdata
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [LINE_W-1:0] mem [0:DEPTH-1];
    logic [LINE_W-1:0] rdata_reg;

    // Storage itself is never reset so it stays a plain RAM.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_reg <= '0;
        end else if (en && !we) begin
            rdata_reg <= mem[addr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/slow_mem_responder.sv
// Fixed-latency line memory responder: accepts one read or write, answers
// with a single-cycle mem_ready pulse LATENCY cycles after acceptance.
module slow_mem_responder
    import mem_if_pkg::*;
#(
    parameter int LATENCY    = 8,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    slow_mem_responder_if.slave        bus,
    output logic                       proto_err
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t                 state_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic                   op_write_reg;
    logic [DEPTH_LOG2-1:0]  idx_reg;
    logic [LINE_W-1:0]      wdata_reg;
    logic                   ready_reg;
    logic                   proto_err_reg;

    logic                   array_en;
    logic [LINE_W-1:0]      array_rdata;

    // The array access happens on the edge that leaves RESP, so the pulse
    // (registered from RESP) lands exactly LATENCY cycles after acceptance
    // and the following TURN cycle is the one that carries mem_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            op_write_reg  <= 1'b0;
            idx_reg       <= '0;
            wdata_reg     <= '0;
            ready_reg     <= 1'b0;
            proto_err_reg <= 1'b0;
        end else begin
            ready_reg <= (state_reg == RESP);
            case (state_reg)
                IDLE: begin
                    if (bus.mem_read || bus.mem_write) begin
                        op_write_reg <= bus.mem_write;
                        idx_reg      <= bus.mem_addr[ADDR_LO+DEPTH_LOG2-1:ADDR_LO];
                        wdata_reg    <= bus.mem_wdata;
                        cnt_reg      <= CNT_LOAD;
                        if (bus.mem_read && bus.mem_write) begin
                            proto_err_reg <= 1'b1;
                        end
                        state_reg <= (LATENCY == 1) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt_reg <= cnt_reg - CNT_ONE;
                    if (cnt_reg == CNT_ONE) begin
                        state_reg <= RESP;
                    end
                end
                RESP: begin
                    state_reg <= TURN;
                end
                TURN: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign array_en = (state_reg == RESP);

    mem_line_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (array_en),
        .we    (op_write_reg),
        .addr  (idx_reg),
        .wdata (wdata_reg),
        .rdata (array_rdata)
    );

    assign bus.mem_rdata = array_rdata;
    assign bus.mem_ready = ready_reg;
    assign proto_err     = proto_err_reg;

endmodule

// File: tb/tb_slow_mem_responder.sv
// Directed scoreboard bench for slow_mem_responder (LATENCY=8 main instance,
// LATENCY=1 side instance for the minimum-latency case).
module tb_slow_mem_responder;
    import mem_if_pkg::*;

    localparam int LAT = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic proto_err;
    logic proto_err1;

    int cyc    = 0;
    int errors = 0;
    int checks = 0;
    bit prev_ready = 1'b0;

    typedef struct {
        bit           is_read;
        logic [127:0] data;
        int           due;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    localparam logic [127:0] LINE3 = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] ONES  = {128{1'b1}};
    localparam logic [127:0] A5    = {16{8'hA5}};
    localparam logic [127:0] DEAD  = {4{32'hDEADBEEF}};
    localparam logic [127:0] FIVEA = {16{8'h5A}};

    slow_mem_responder_if bus ();
    slow_mem_responder_if bus1 ();

    slow_mem_responder #(.LATENCY(LAT), .DEPTH_LOG2(8)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .proto_err (proto_err)
    );

    slow_mem_responder #(.LATENCY(1), .DEPTH_LOG2(4)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus1),
        .proto_err (proto_err1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [127:0] pre(input int i);
        logic [31:0] w;
        w = 32'hC0DE0000 | i;
        return {4{w}};
    endfunction

    // Monitor: pops the scoreboard on every mem_ready, checks outputs in reset.
    always @(negedge clk) begin
        if (!rst_n) begin
            checks++;
            if (bus.mem_ready !== 1'b0 || bus.mem_rdata !== '0 || proto_err !== 1'b0 ||
                bus1.mem_ready !== 1'b0 || bus1.mem_rdata !== '0 || proto_err1 !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs cyc=%0d: ready=%b rdata=%h perr=%b ready1=%b perr1=%b, required all 0",
                         cyc, bus.mem_ready, bus.mem_rdata, proto_err, bus1.mem_ready, proto_err1);
            end
            prev_ready = 1'b0;
        end else begin
            if (bus.mem_ready === 1'b1) begin
                checks++;
                if (prev_ready) begin
                    errors++;
                    $display("FAIL ready_width cyc=%0d: ready high 2 cycles, required 1", cyc);
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ready cyc=%0d: pulse with no request pending", cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    checks++;
                    if (cyc != mon_e.due) begin
                        errors++;
                        $display("FAIL ready_cycle: got cycle %0d, required %0d", cyc, mon_e.due);
                    end
                    if (mon_e.is_read) begin
                        checks++;
                        if (bus.mem_rdata !== mon_e.data) begin
                            errors++;
                            $display("FAIL rdata cyc=%0d: got %h, required %h", cyc, bus.mem_rdata, mon_e.data);
                        end
                    end
                    $display("txn done cyc=%0d %s rdata=%h", cyc, mon_e.is_read ? "read " : "write", bus.mem_rdata);
                end
            end
            prev_ready = (bus.mem_ready === 1'b1);
        end
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    // Issues one request on the main bus at the next negedge and waits for its pulse.
    task automatic do_req(input bit rd, input bit wr, input logic [27:0] addr,
                          input logic [127:0] wd, input logic [127:0] exp_data,
                          input int drop_at, input int extra, output int rdy_cyc);
        int n;
        @(negedge clk);
        bus.mem_read  = rd;
        bus.mem_write = wr;
        bus.mem_addr  = addr;
        bus.mem_wdata = wd;
        exp_q.push_back('{rd && !wr, exp_data, cyc + 1 + LAT});
        $display("txn issue cyc=%0d rd=%0b wr=%0b addr=%h wdata=%h", cyc, rd, wr, addr, wd);
        n = 0;
        rdy_cyc = -1;
        do begin
            @(negedge clk);
            n++;
            if (drop_at > 0 && n == drop_at) begin
                bus.mem_read  = 1'b0;
                bus.mem_write = 1'b0;
            end
        end while (bus.mem_ready !== 1'b1 && n < 4 * LAT);
        checks++;
        if (bus.mem_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_timeout: no pulse within %0d cycles for addr=%h", n, addr);
            exp_q.delete();
        end else begin
            rdy_cyc = cyc;
        end
        repeat (extra) @(negedge clk);
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    // LATENCY=1 instance: pulse must be in the cycle right after acceptance.
    task automatic l1_req(input bit rd, input bit wr, input logic [27:0] addr,
                          input logic [127:0] wd, input logic [127:0] exp_data);
        @(negedge clk);
        bus1.mem_read  = rd;
        bus1.mem_write = wr;
        bus1.mem_addr  = addr;
        bus1.mem_wdata = wd;
        $display("txn issue L1 cyc=%0d rd=%0b wr=%0b addr=%h", cyc, rd, wr, addr);
        @(negedge clk);
        check("l1_ready_acc_cycle", {127'd0, bus1.mem_ready}, 128'd0);
        @(negedge clk);
        check("l1_ready_next_cycle", {127'd0, bus1.mem_ready}, 128'd1);
        if (rd) check("l1_rdata", bus1.mem_rdata, exp_data);
        bus1.mem_read  = 1'b0;
        bus1.mem_write = 1'b0;
        @(negedge clk);
        check("l1_ready_drop", {127'd0, bus1.mem_ready}, 128'd0);
        $display("txn done L1 cyc=%0d rdata=%h", cyc, bus1.mem_rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r1;
        int r2;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus1.mem_read  = 1'b0;
        bus1.mem_write = 1'b0;
        bus1.mem_addr  = '0;
        bus1.mem_wdata = '0;
        for (int i = 0; i < 256; i++) u_dut.u_array.mem[i] = pre(i);
        u_dut.u_array.mem[3] = LINE3;
        for (int i = 0; i < 16; i++) u_dut1.u_array.mem[i] = pre(i);

        while (cyc != 2) @(negedge clk);
        #2 rst_n = 1'b1;

        // Read line 3, accepted at edge 10, pulse in cycle 18.
        while (cyc != 8) @(negedge clk);
        do_req(1'b1, 1'b0, 28'h3, '0, LINE3, 0, 0, r1);
        check("t1_ready_cycle", 128'(r1), 128'd18);

        // Write line 5 = ones, read back, neighbours untouched.
        do_req(1'b0, 1'b1, 28'h5, ONES, '0, 0, 0, r1);
        do_req(1'b1, 1'b0, 28'h5, '0, ONES, 0, 0, r2);
        check("t2_pulse_gap", 128'(r2 - r1), 128'd10);
        do_req(1'b1, 1'b0, 28'h4, '0, pre(4), 0, 0, r1);
        do_req(1'b1, 1'b0, 28'h6, '0, pre(6), 0, 0, r1);

        // Request held through TURN: no double service.
        do_req(1'b1, 1'b0, 28'h4, '0, pre(4), 0, 1, r1);
        do_req(1'b1, 1'b0, 28'h3, '0, LINE3, 0, 0, r2);
        check("t3_rerequest_gap", 128'(r2 - r1), 128'd11);

        // Read and write together: write wins, proto_err sticks.
        do_req(1'b1, 1'b1, 28'h7, A5, '0, 0, 0, r1);
        @(negedge clk);
        check("t4_proto_err_set", {127'd0, proto_err}, 128'd1);
        do_req(1'b1, 1'b0, 28'h7, '0, A5, 0, 0, r1);
        check("t4_proto_err_sticky", {127'd0, proto_err}, 128'd1);

        // Reset in the middle of a write to line 9 aborts it.
        @(negedge clk);
        bus.mem_write = 1'b1;
        bus.mem_addr  = 28'h9;
        bus.mem_wdata = DEAD;
        $display("txn issue cyc=%0d write addr=9 (to be aborted by reset)", cyc);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        bus.mem_write = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_proto_err_cleared", {127'd0, proto_err}, 128'd0);
        #2 rst_n = 1'b1;
        do_req(1'b1, 1'b0, 28'h9, '0, pre(9), 0, 0, r1);
        check("t5_proto_err_after_reset", {127'd0, proto_err}, 128'd0);

        // Request dropped during WAIT still completes.
        do_req(1'b1, 1'b0, 28'h3, '0, LINE3, 3, 0, r1);
        // Higher address bits are ignored: 0x105 aliases line 5.
        do_req(1'b1, 1'b0, 28'h105, '0, ONES, 0, 0, r1);

        // Minimum latency instance.
        l1_req(1'b1, 1'b0, 28'h2, '0, pre(2));
        l1_req(1'b0, 1'b1, 28'h2, FIVEA, '0);
        l1_req(1'b1, 1'b0, 28'h2, '0, FIVEA);

        repeat (4) @(negedge clk);
        check("scoreboard_empty", 128'(exp_q.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
